// File: rtl/vga_sync_gen.sv
// VGA timing master: pixel prescaler, h/v scan counters, sync pulses
// and visible-area flag for 640x480 @ 60 Hz.
module vga_sync_gen #(
    parameter int DIV = 4,
    parameter int HD  = 640,
    parameter int HF  = 16,
    parameter int HR  = 96,
    parameter int HB  = 48,
    parameter int VD  = 480,
    parameter int VF  = 10,
    parameter int VR  = 2,
    parameter int VB  = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       p_tick,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       frame_start
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
    localparam logic [PW-1:0] PONE = PW'(1);

    localparam logic [9:0] HMAX = 10'(HD + HF + HR + HB - 1);
    localparam logic [9:0] VMAX = 10'(VD + VF + VR + VB - 1);
    localparam logic [9:0] HS0  = 10'(HD + HF);
    localparam logic [9:0] HS1  = 10'(HD + HF + HR - 1);
    localparam logic [9:0] VS0  = 10'(VD + VF);
    localparam logic [9:0] VS1  = 10'(VD + VF + VR - 1);
    localparam logic [9:0] HVIS = 10'(HD);
    localparam logic [9:0] VVIS = 10'(VD);

    logic [PW-1:0] pre;
    logic [9:0]    h_cnt;
    logic [9:0]    v_cnt;
    logic [9:0]    h_nx;
    logic [9:0]    v_nx;
    logic          h_end;
    logic          v_end;

    // ">=" rather than "==" so an upset counter wraps on the next tick
    always_comb begin
        h_end = (h_cnt >= HMAX);
        v_end = (v_cnt >= VMAX);
        h_nx  = h_end ? '0 : h_cnt + 10'd1;
        v_nx  = v_cnt;
        if (h_end)
            v_nx = v_end ? '0 : v_cnt + 10'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre    <= '0;
            p_tick <= 1'b0;
        end else begin
            pre    <= (pre == PMAX) ? '0 : pre + PONE;
            p_tick <= (pre == PMAX);
        end
    end

    // Syncs decoded from next counts so they line up with pixel_x/y
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_cnt <= '0;
            v_cnt <= '0;
            hsync <= 1'b1;
            vsync <= 1'b1;
        end else if (p_tick) begin
            h_cnt <= h_nx;
            v_cnt <= v_nx;
            hsync <= !((h_nx >= HS0) && (h_nx <= HS1));
            vsync <= !((v_nx >= VS0) && (v_nx <= VS1));
        end
    end

    assign pixel_x     = h_cnt;
    assign pixel_y     = v_cnt;
    assign video_on    = reset && (h_cnt < HVIS) && (v_cnt < VVIS);
    assign frame_start = p_tick && h_end && v_end;

endmodule
